// File: rtl/mpu_unary_seq_pkg.sv
// rtl/mpu_unary_seq_pkg.sv - shared encodings and helpers for the MPU unary sequencer
package mpu_pkg;

    typedef enum logic [1:0] {
        MODE_NEG       = 2'd0,
        MODE_TRANSPOSE = 2'd1,
        MODE_SCALE     = 2'd2,
        MODE_COPY      = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Flat-bus bit offset of element (line i, position j) in an n x n matrix of w-bit elements.
    function automatic int bit_off(input int i, input int j, input int n, input int w);
        return w * (i * n + j);
    endfunction

    // Clamp a wide signed value into the signed range of a w-bit element.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/mpu_unary_seq_if.sv
// rtl/mpu_unary_seq_if.sv - operand/result bundle between a controller and the unary sequencer
interface mpu_unary_seq_if #(
    parameter int N      = 5,
    parameter int ELEM_W = 8
);
    logic                       start;
    logic [1:0]                 mode;
    logic signed [ELEM_W-1:0]   scalar;
    logic [ELEM_W*N*N-1:0]      matrix_a;
    logic [ELEM_W*N*N-1:0]      result;
    logic                       busy;
    logic                       done;
    logic                       overflow;

    modport master (
        output start, mode, scalar, matrix_a,
        input  result, busy, done, overflow
    );

    modport slave (
        input  start, mode, scalar, matrix_a,
        output result, busy, done, overflow
    );
endinterface

// File: rtl/mpu_unary_seq_elem_alu.sv
// rtl/mpu_unary_seq_elem_alu.sv - combinational single-element negate/scale/pass with overflow detect
module mpu_elem_alu
    import mpu_pkg::*;
#(
    parameter int ELEM_W   = 8,
    parameter bit SATURATE = 1'b1
) (
    input  mode_e                    i_mode,
    input  logic signed [ELEM_W-1:0] i_a,
    input  logic signed [ELEM_W-1:0] i_scalar,
    output logic signed [ELEM_W-1:0] o_r,
    output logic                     o_ovf
);
    localparam logic signed [ELEM_W-1:0] MIN_V = {1'b1, {(ELEM_W-1){1'b0}}};
    localparam logic signed [ELEM_W-1:0] MAX_V = ~MIN_V;

    logic signed [2*ELEM_W-1:0] w_prod;
    logic signed [63:0]         w_prod_ext;
    logic signed [63:0]         w_prod_sat;

    assign w_prod     = (2*ELEM_W)'(i_a) * (2*ELEM_W)'(i_scalar);
    assign w_prod_ext = 64'(w_prod);
    assign w_prod_sat = sat_clamp(w_prod_ext, ELEM_W);

    // Transpose and copy pass the (already reordered) operand straight through.
    always_comb begin
        o_r   = i_a;
        o_ovf = 1'b0;
        case (i_mode)
            MODE_NEG: begin
                if (i_a == MIN_V) begin
                    o_ovf = 1'b1;
                    o_r   = SATURATE ? MAX_V : MIN_V;
                end else begin
                    o_r = -i_a;
                end
            end
            MODE_SCALE: begin
                o_ovf = (w_prod_sat != w_prod_ext);
                o_r   = SATURATE ? w_prod_sat[ELEM_W-1:0] : w_prod[ELEM_W-1:0];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mpu_unary_seq.sv
// rtl/mpu_unary_seq.sv - latches an NxN matrix and emits one unary-op result line per clock
module mpu_unary_seq
    import mpu_pkg::*;
#(
    parameter int N        = 5,
    parameter int ELEM_W   = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    mpu_unary_seq_if.slave  bus
);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_e                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    mode_e                    r_mode;
    logic signed [ELEM_W-1:0] r_scalar;
    logic [ELEM_W*N*N-1:0]    r_a;
    logic signed [ELEM_W-1:0] r_res [N][N];
    logic                     r_busy;
    logic                     r_done;
    logic                     r_ovf;

    logic signed [ELEM_W-1:0] w_elem [N][N];
    logic signed [ELEM_W-1:0] w_line [N];
    logic signed [ELEM_W-1:0] w_res  [N];
    logic [N-1:0]             w_ovf;
    logic [ELEM_W*N*N-1:0]    w_result;

    // w_elem[i][j] is captured element a[i][j]; the line mux picks a row, or a column for transpose.
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            assign w_elem[gi][gj] = r_a[bit_off(gi, gj, N, ELEM_W) +: ELEM_W];
            assign w_result[bit_off(gi, gj, N, ELEM_W) +: ELEM_W] = r_res[gi][gj];
        end
    end

    for (genvar gj = 0; gj < N; gj++) begin : g_lane
        assign w_line[gj] = (r_mode == MODE_TRANSPOSE) ? w_elem[gj][r_cnt] : w_elem[r_cnt][gj];

        mpu_elem_alu #(
            .ELEM_W   (ELEM_W),
            .SATURATE (SATURATE)
        ) u_alu (
            .i_mode   (r_mode),
            .i_a      (w_line[gj]),
            .i_scalar (r_scalar),
            .o_r      (w_res[gj]),
            .o_ovf    (w_ovf[gj])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mode   <= MODE_NEG;
            r_scalar <= '0;
            r_a      <= '0;
            r_res    <= '{default: '0};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state  <= RUN;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_ovf    <= 1'b0;
                        r_mode   <= mode_e'(bus.mode);
                        r_scalar <= bus.scalar;
                        r_a      <= bus.matrix_a;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_res[r_cnt] <= w_res;
                    r_ovf        <= r_ovf | (|w_ovf);
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result   = w_result;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_mpu_unary_seq.sv
// tb/tb_mpu_unary_seq.sv - directed self-checking bench for mpu_unary_seq (saturating and wrapping builds)
module tb_mpu_unary_seq;
    localparam int N  = 5;
    localparam int W  = 8;
    localparam int BW = W * N * N;
    localparam logic [1:0] M_NEG   = 2'd0;
    localparam logic [1:0] M_TRANS = 2'd1;
    localparam logic [1:0] M_SCALE = 2'd2;
    localparam logic [1:0] M_COPY  = 2'd3;

    typedef int mat_t [N][N];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    mpu_unary_seq_if #(.N(N), .ELEM_W(W)) bus_s ();
    mpu_unary_seq_if #(.N(N), .ELEM_W(W)) bus_w ();

    mpu_unary_seq #(.N(N), .ELEM_W(W), .SATURATE(1'b1)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    mpu_unary_seq #(.N(N), .ELEM_W(W), .SATURATE(1'b0)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] pack(input mat_t m);
        logic [BW-1:0] v;
        int            e;
        v = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                e = m[i][j];
                v[W*(i*N+j) +: W] = e[W-1:0];
            end
        end
        return v;
    endfunction

    function automatic logic [BW-1:0] fill(input int val);
        mat_t m;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                m[i][j] = val;
            end
        end
        return pack(m);
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [1:0] md, input int sc, input logic [BW-1:0] mat);
        bus_s.start = st;   bus_w.start = st;
        bus_s.mode = md;    bus_w.mode = md;
        bus_s.scalar = sc[W-1:0];
        bus_w.scalar = sc[W-1:0];
        bus_s.matrix_a = mat;
        bus_w.matrix_a = mat;
    endtask

    task automatic set_start(input logic st);
        bus_s.start = st;
        bus_w.start = st;
    endtask

    task automatic launch(input logic [1:0] md, input int sc, input logic [BW-1:0] mat);
        drive(1'b1, md, sc, mat);
        @(posedge clk);
        #1;
        set_start(1'b0);
    endtask

    task automatic wait_done(inout int edges);
        while (!bus_s.done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic run_op(input logic [1:0] md, input int sc, input logic [BW-1:0] mat, output int edges);
        launch(md, sc, mat);
        edges = 1;
        wait_done(edges);
    endtask

    mat_t a1, e1, a2, e2s, e2w, a3, e3;
    int   edges;
    logic seen;

    initial begin
        a1  = '{'{2, -1, 0, 4, 5}, '{12, 7, 8, 9, 10}, '{22, 12, 13, 14, 15},
                '{32, 17, 18, 19, 20}, '{45, 22, 23, 24, 1}};
        e1  = '{'{-2, 1, 0, -4, -5}, '{-12, -7, -8, -9, -10}, '{-22, -12, -13, -14, -15},
                '{-32, -17, -18, -19, -20}, '{-45, -22, -23, -24, -1}};
        a2  = a1;  a2[0][0]  = -128;
        e2s = e1;  e2s[0][0] = 127;
        e2w = e1;  e2w[0][0] = -128;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a3[i][j] = 10 * i + j;
                e3[i][j] = 10 * j + i;
            end
        end

        drive(1'b0, M_NEG, 0, '0);
        #12;
        chk("rst_result", bus_s.result, '0);
        chk("rst_busy", bus_s.busy, 0);
        chk("rst_done", bus_s.done, 0);
        chk("rst_ovf", bus_s.overflow, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Negate, plain values
        launch(M_NEG, 0, pack(a1));
        chk("t1_busy_run", bus_s.busy, 1);
        chk("t1_done_run", bus_s.done, 0);
        edges = 1;
        wait_done(edges);
        chk("t1_latency", edges, 6);
        chk("t1_res_sat", bus_s.result, pack(e1));
        chk("t1_res_wrap", bus_w.result, pack(e1));
        chk("t1_ovf", bus_s.overflow, 0);
        chk("t1_busy_done", bus_s.busy, 0);
        @(posedge clk);
        #1;
        chk("t1_done_pulse", bus_s.done, 0);

        // Negate of the most negative value
        run_op(M_NEG, 0, pack(a2), edges);
        chk("t2_res_sat", bus_s.result, pack(e2s));
        chk("t2_res_wrap", bus_w.result, pack(e2w));
        chk("t2_ovf_sat", bus_s.overflow, 1);
        chk("t2_ovf_wrap", bus_w.overflow, 1);

        // Transpose
        run_op(M_TRANS, 0, pack(a3), edges);
        chk("t3_latency", edges, 6);
        chk("t3_res", bus_s.result, pack(e3));
        chk("t3_e13", bus_s.result[W*(1*N+3) +: W], 8'd31);
        chk("t3_ovf_cleared", bus_s.overflow, 0);

        // Scale
        run_op(M_SCALE, -3, fill(40), edges);
        chk("t4a_res", bus_s.result, fill(-120));
        chk("t4a_ovf", bus_s.overflow, 0);
        run_op(M_SCALE, 4, fill(40), edges);
        chk("t4b_res_sat", bus_s.result, fill(127));
        chk("t4b_res_wrap", bus_w.result, fill(-96));
        chk("t4b_ovf", bus_s.overflow, 1);
        chk("t4b_ovf_wrap", bus_w.overflow, 1);
        run_op(M_SCALE, 3, fill(-50), edges);
        chk("t4c_res_sat", bus_s.result, fill(-128));
        chk("t4c_res_wrap", bus_w.result, fill(106));
        chk("t4c_ovf", bus_s.overflow, 1);

        // Start in RUN ignored, operand change mid-run ignored, back-to-back via DONE
        launch(M_COPY, 0, pack(a3));
        edges = 1;
        @(posedge clk);
        #1;
        edges++;
        drive(1'b1, M_NEG, 5, pack(a1));
        @(posedge clk);
        #1;
        edges++;
        set_start(1'b0);
        wait_done(edges);
        chk("t5_latency_ignored_start", edges, 6);
        chk("t5_res_captured", bus_s.result, pack(a3));
        chk("t5_done_wrap", bus_w.done, 1);
        drive(1'b1, M_NEG, 0, pack(a1));
        @(posedge clk);
        #1;
        set_start(1'b0);
        edges = 1;
        chk("t5_b2b_busy", bus_s.busy, 1);
        chk("t5_b2b_done_low", bus_s.done, 0);
        wait_done(edges);
        chk("t5_b2b_spacing", edges, 6);
        chk("t5_b2b_res", bus_s.result, pack(e1));

        // Reset mid-run
        launch(M_NEG, 0, pack(a2));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_res", bus_s.result, '0);
        chk("t6_rst_res_wrap", bus_w.result, '0);
        chk("t6_rst_busy", bus_s.busy, 0);
        chk("t6_rst_done", bus_s.done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (bus_s.done || bus_w.done) seen = 1'b1;
        end
        chk("t6_no_done", seen, 0);
        run_op(M_NEG, 0, pack(a1), edges);
        chk("t6_after_latency", edges, 6);
        chk("t6_after_res", bus_s.result, pack(e1));
        chk("t6_after_ovf", bus_s.overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mpu_unary_seq.md
Name: mpu_unary_seq

Overview:
Sequential, parametrised successor of the combinational matrix-opposite unit. It latches an N×N signed matrix on `start` and applies one of four unary operations, one result line per clock: negate, transpose, scalar multiply, or copy. Negate and scale have optional saturation and a sticky overflow flag. It sits in the MPU datapath beside the other matrix-operation units and uses the same flattened matrix bus layout.

Parameters:
- N, 5, matrix dimension (N×N elements), legal range 2..8
- ELEM_W, 8, element width in bits, signed two's complement
- SATURATE, 1, 1 = clamp out-of-range results to min/max; 0 = wrap (keep the low ELEM_W bits)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a new operation; sampled only in IDLE or DONE
- mode  in  2  operation: 0 NEG, 1 TRANSPOSE, 2 SCALE, 3 COPY; latched with start
- scalar  in  ELEM_W  signed multiplier for SCALE; latched with start
- matrix_a  in  ELEM_W*N*N  operand; element e[i][j] (line i, position j) at bits ELEM_W*(i*N+j) +: ELEM_W
- result  out  ELEM_W*N*N  registered result, same layout
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; result is complete and stable
- overflow  out  1  sticky per operation; valid with done

Behaviour:
- Reset (async, any state): state=IDLE, line counter=0, result=0, busy=0, done=0, overflow=0.
- States and transitions:
  - IDLE: on start, go to RUN.
  - RUN: go to DONE after line N-1 is written.
  - DONE: lasts one cycle. On start, go to RUN (back-to-back); otherwise go to IDLE.
- Capture: at the accepting edge k, latch matrix_a, mode and scalar into internal registers; set the line counter to 0; clear overflow.
- Input changes after edge k have no effect on the running operation.
- Edges k+1 .. k+N: write result line `cnt`, increment cnt. At edge k+N the state moves to DONE.
- done=1 during the cycle after edge k+N, so latency is N+1 edges from start to done.
- busy = (state==RUN). start while in RUN is ignored.
- result lines not yet written in RUN hold their previous values. result holds after DONE until the next operation overwrites it.
- Per-element operations on line cnt (N elements computed in parallel):
  - NEG: r = -a[cnt][j]. Only -2^(W-1) overflows: it gives 2^(W-1)-1 if SATURATE, else -2^(W-1). Either way overflow is set.
  - TRANSPOSE: r[cnt][j] = a[j][cnt]. Never overflows.
  - SCALE: form the 2W-bit signed product a*scalar. If it lies outside [-2^(W-1), 2^(W-1)-1], set overflow; clamp if SATURATE, else take the low W bits.
  - COPY: r = a. Never overflows.
- overflow is the OR over all elements of the operation, accumulated as lines are written. It is cleared at the next accepted start.
- Reset mid-RUN: returns immediately to the reset state. No done pulse; result is zeroed.

Decomposition:
- Package mpu_pkg holds:
  - mode encodings MODE_NEG/MODE_TRANSPOSE/MODE_SCALE/MODE_COPY
  - state encoding IDLE/RUN/DONE
  - a function computing the flat-bus bit offset for (i, j, N, ELEM_W)
  - a saturation helper function
- Sub-module mpu_elem_alu: combinational single-element op (mode, a, scalar → r, ovf), parametrised by ELEM_W and SATURATE. It is instantiated N times via generate for one line per cycle.
- The top level holds the FSM, line counter, capture registers, transpose select mux and result register.

Test Plan:
1. N=5, W=8, NEG on rows {2,-1,0,4,5},{12,7,8,9,10},{22,12,13,14,15},{32,17,18,19,20},{45,22,23,24,1} → done exactly 6 edges after start; result rows {-2,1,0,-4,-5},…,{-45,-22,-23,-24,-1}; overflow=0.
2. NEG with e[0][0]=-128: SATURATE=1 → 127 and overflow=1; SATURATE=0 instance → -128 and overflow=1.
3. TRANSPOSE of e[i][j]=10*i+j → result e[i][j]=10*j+i; e[1][3]=31; overflow=0.
4. SCALE with scalar=-3, e=40 → -120, no overflow; scalar=4, e=40 → 127 (SAT) or -96 (wrap), overflow=1; e=-50, scalar=3 → -128 (SAT), overflow=1.
5. Handshake: start pulsed in RUN → ignored; start held during the DONE cycle → second op begins, done spacing 6 cycles; matrix_a changed mid-RUN → result reflects the captured matrix.
6. rst asserted at RUN line 2 → result=0, busy=0, done never pulses; a following start completes normally with overflow cleared.
